// File: rtl/axi_lite_cfg_master.sv
// AXI4-Lite configuration master.
// Turns one command (read or write of a single register) into an AXI4-Lite
// transaction. It returns a one-cycle completion pulse carrying the read
// data and the response code. A cycle budget aborts the transaction with a
// SLVERR-style timeout response when the slave stalls.
module axi_lite_cfg_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  // The timeout fires in the TIMEOUT-th active cycle. The counter holds
  // the number of active cycles already completed.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t                state_r, state_s;
  logic [15:0]           cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  cmd_ready_r;
  logic                  awvalid_r, awvalid_s;
  logic                  wvalid_r, wvalid_s;
  logic                  arvalid_r, arvalid_s;
  logic                  bready_r, rready_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
  logic [1:0]            rsp_resp_r, rsp_resp_s;
  logic                  rsp_timeout_r, rsp_timeout_s;
  logic                  accept_s;
  logic                  expired_s;
  logic                  active_s;
  logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                  aw_ok_s, w_ok_s;

  assign aw_hs_s   = awvalid_r & m_axi_awready;
  assign w_hs_s    = wvalid_r & m_axi_wready;
  assign b_hs_s    = bready_r & m_axi_bvalid;
  assign ar_hs_s   = arvalid_r & m_axi_arready;
  assign r_hs_s    = rready_r & m_axi_rvalid;
  // A channel counts as finished once its valid has dropped or it is
  // handshaking right now.
  assign aw_ok_s   = ~awvalid_r | aw_hs_s;
  assign w_ok_s    = ~wvalid_r | w_hs_s;
  assign expired_s = (cnt_r >= TIMEOUT_LAST);
  assign active_s  = (state_r == WR_REQ) || (state_r == WR_RESP) ||
                     (state_r == RD_REQ) || (state_r == RD_RESP);

  // Next-state and next-output decode; handshakes win over timeout expiry.
  always_comb begin
    state_s       = state_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    arvalid_s     = arvalid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_resp_s    = rsp_resp_r;
    rsp_timeout_s = rsp_timeout_r;
    accept_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s = 1'b1;
          if (cmd_write) begin
            state_s   = WR_REQ;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            state_s   = RD_REQ;
            arvalid_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_REQ: begin
        if (aw_hs_s || w_hs_s) begin
          if (aw_hs_s) begin
            awvalid_s = 1'b0;
          end else begin
            awvalid_s = awvalid_r;
          end
          if (w_hs_s) begin
            wvalid_s = 1'b0;
          end else begin
            wvalid_s = wvalid_r;
          end
          if (aw_ok_s && w_ok_s) begin
            state_s = WR_RESP;
          end else begin
            state_s = WR_REQ;
          end
        end else if (expired_s) begin
          awvalid_s     = 1'b0;
          wvalid_s      = 1'b0;
          state_s       = DONE;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_resp_s    = 2'b10;
          rsp_timeout_s = 1'b1;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          state_s       = DONE;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_resp_s    = m_axi_bresp;
          rsp_timeout_s = 1'b0;
        end else if (expired_s) begin
          state_s       = DONE;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_resp_s    = 2'b10;
          rsp_timeout_s = 1'b1;
        end else begin
          state_s = WR_RESP;
        end
      end
      RD_REQ: begin
        if (ar_hs_s) begin
          arvalid_s = 1'b0;
          state_s   = RD_RESP;
        end else if (expired_s) begin
          arvalid_s     = 1'b0;
          state_s       = DONE;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_resp_s    = 2'b10;
          rsp_timeout_s = 1'b1;
        end else begin
          state_s = RD_REQ;
        end
      end
      RD_RESP: begin
        if (r_hs_s) begin
          state_s       = DONE;
          rsp_rdata_s   = m_axi_rdata;
          rsp_resp_s    = m_axi_rresp;
          rsp_timeout_s = 1'b0;
        end else if (expired_s) begin
          state_s       = DONE;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_resp_s    = 2'b10;
          rsp_timeout_s = 1'b1;
        end else begin
          state_s = RD_RESP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        arvalid_s = 1'b0;
      end
    endcase
  end

  // State and registered handshake/response outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cmd_ready_r   <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      bready_r      <= 1'b0;
      rready_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cmd_ready_r   <= (state_s == IDLE);
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      arvalid_r     <= arvalid_s;
      bready_r      <= (state_s == WR_RESP);
      rready_r      <= (state_s == RD_RESP);
      rsp_valid_r   <= (state_s == DONE);
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  // Command address and write data latch; held stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      addr_r  <= cmd_addr;
      wdata_r <= cmd_wdata;
    end
  end

  // Transaction cycle counter: cleared on accept, saturating count of active cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (accept_s) begin
      cnt_r <= 16'd0;
    end else if (active_s && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: doc/axi_lite_cfg_master.md
AXI_LITE_CFG_MASTER -- requirements
Module: axi_lite_cfg_master

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  ADDR_WIDTH, 4, AXI4-Lite address width.
  DATA_WIDTH, 32, AXI4-Lite data width.
  TIMEOUT, 255, maximum cycles from command accept to completion (range 1..65535).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all logic on rising edge.
  rst  in  1  synchronous, active-high reset.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  command accepted when high together with cmd_valid.
  cmd_write  in  1  1 = write, 0 = read.
  cmd_addr  in  ADDR_WIDTH  target register address.
  cmd_wdata  in  DATA_WIDTH  write data.
  rsp_valid  out  1  one-cycle completion pulse.
  rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
  rsp_resp  out  2  AXI response code.
  rsp_timeout  out  1  completion caused by timeout.
  m_axi_awaddr/awvalid  out  ADDR_WIDTH/1  write address channel.
  m_axi_awready  in  1
  m_axi_wdata/wvalid  out  DATA_WIDTH/1  write data channel.
  m_axi_wready  in  1
  m_axi_bresp/bvalid  in  2/1  write response channel.
  m_axi_bready  out  1
  m_axi_araddr/arvalid  out  ADDR_WIDTH/1  read address channel.
  m_axi_arready  in  1
  m_axi_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  read data channel.
  m_axi_rready  out  1
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-004 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, addr/wdata/write SHALL be latched and the FSM SHALL move to WR_REQ (write) or RD_REQ (read).
REQ-006 WR_REQ: awvalid and wvalid SHALL rise the cycle after accept; each SHALL drop on the cycle after its own handshake, independently; awaddr/wdata SHALL be stable while valid; both handshakes done -> WR_RESP.
REQ-007 WR_RESP: bready=1; on bvalid&&bready, bresp SHALL be captured -> DONE.
REQ-008 RD_REQ: arvalid SHALL rise the cycle after accept, held with stable araddr until arready -> RD_RESP.
REQ-009 RD_RESP: rready=1; on rvalid&&rready, rdata/rresp SHALL be captured -> DONE.
REQ-010 bready/rready SHALL be 0 outside WR_RESP/RD_RESP; B/R beats arriving early SHALL be left pending until that state.
REQ-011 DONE: rsp_valid=1 for exactly one cycle with captured rsp_rdata (0 for writes) and rsp_resp; then -> IDLE.
REQ-012 rsp_* SHALL hold their last values when rsp_valid=0.
REQ-013 Minimum latency with an always-ready slave SHALL be: accept at cycle N, request at N+1, response handshake at N+2, rsp_valid at N+3.
REQ-014 A 16-bit cycle counter SHALL clear on accept and increment each non-IDLE, non-DONE cycle; on reaching TIMEOUT, all m_axi valids/readys SHALL drop and the FSM SHALL enter DONE with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-015 A handshake in the same cycle as timeout expiry SHALL take priority; the transaction proceeds normally.
REQ-016 No new command SHALL be accepted until the rsp_valid pulse has been issued.

Reset
REQ-017 While rst=1, state SHALL go to IDLE and all outputs SHALL be 0, including cmd_ready, rsp_* and all m_axi_* outputs; cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction with no rsp_valid, and all m_axi valids SHALL be 0 in the cycle after the reset edge.

Verification
REQ-019 Write addr=0x4, data=0xDEADBEEF with an always-ready slave, bresp=00 -> AW/W at N+1, rsp_valid at N+3, rsp_resp=00, rsp_rdata=0.
REQ-020 Read addr=0x8 with the slave returning 0x12345678, rresp=00 -> rsp_rdata=0x12345678 one cycle after the R handshake.
REQ-021 Write where wready arrives 3 cycles after awready -> awvalid drops after its handshake, wvalid is held with stable data, and exactly one rsp_valid pulse occurs.
REQ-022 TIMEOUT=8 with the slave never asserting arready -> arvalid drops, rsp_valid with rsp_timeout=1 and rsp_resp=10, and the block accepts the next command.
REQ-023 rst pulsed while in WR_RESP -> all outputs 0, no rsp_valid, and cmd_ready=1 in the cycle after rst releases.
REQ-024 cmd_valid held high throughout a transaction -> the second command is accepted only in the IDLE cycle after the DONE pulse.
